// File: rtl/sand_pkg.sv
// sand_pkg: cell codes, FSM and move types, and row packing helpers for the sand row engine.
package sand_pkg;
  localparam int CELL_BITS = 2;
  localparam int MAX_ROW_BITS = 1024;
  typedef enum logic [CELL_BITS-1:0] {EMPTY = 2'b00, SAND = 2'b01, WALL = 2'b10, WATER = 2'b11} cell_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [2:0] {MV_NONE, MV_DOWN, MV_DIAG_F, MV_DIAG_B, MV_LAT} move_t;
  typedef logic [MAX_ROW_BITS-1:0] row_t;
  // cell 0 is leftmost and sits at the MSBs of a w-cell row
  function automatic cell_t cell_get(row_t row, int w, int k);
    return cell_t'(row[(w-1-k)*CELL_BITS +: CELL_BITS]);
  endfunction
  function automatic row_t cell_set(row_t row, int w, int k, cell_t c);
    row_t r;
    r = row;
    r[(w-1-k)*CELL_BITS +: CELL_BITS] = c;
    return r;
  endfunction
endpackage

// File: rtl/sand_cell_rule.sv
// sand_cell_rule: picks the move for one cell from its neighbourhood.
// SAND_WATER_EN makes WATER mobile, adding a lateral move when all falls are blocked.
module sand_cell_rule
  import sand_pkg::*;
(
  input  cell_t self_i,
  input  cell_t down_i,
  input  cell_t diag_f_i,
  input  cell_t diag_b_i,
  input  cell_t lat_f_i,
  input  logic  moved_i,
  output move_t move_o
);
`ifdef SAND_WATER_EN
  logic mobile;
  assign mobile = !moved_i && (self_i == SAND || self_i == WATER);
  always_comb
    move_o = !mobile ? MV_NONE :
             down_i == EMPTY ? MV_DOWN :
             diag_f_i == EMPTY ? MV_DIAG_F :
             diag_b_i == EMPTY ? MV_DIAG_B :
             (self_i == WATER && lat_f_i == EMPTY) ? MV_LAT : MV_NONE;
`else
  logic unused_lat;
  assign unused_lat = ^{lat_f_i, moved_i};
  always_comb
    move_o = self_i != SAND ? MV_NONE :
             down_i == EMPTY ? MV_DOWN :
             diag_f_i == EMPTY ? MV_DIAG_F :
             diag_b_i == EMPTY ? MV_DIAG_B : MV_NONE;
`endif
endmodule

// File: rtl/sand_row_engine.sv
// sand_row_engine: serial falling-sand updater for one region/floor row pair, one cell per clock.
// SAND_WATER_EN enables mobile water with lateral flow inside the region row.
module sand_row_engine
  import sand_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit ALT_DIR = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH*CELL_BITS-1:0]     in_region,
  input  logic [WIDTH*CELL_BITS-1:0]     in_floor,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH*CELL_BITS-1:0]     out_region,
  output logic [WIDTH*CELL_BITS-1:0]     out_floor,
  output logic [$clog2(WIDTH+1)-1:0]     out_moved,
  output logic                           out_dir
);
  localparam int RW = WIDTH * CELL_BITS;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  state_t          state_q;
  logic            dir_q;
  logic [IW-1:0]   idx_q;
  logic [RW-1:0]   reg_q, reg_d, flr_q, flr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  int              i, fi, bi, tgt;
  logic            fwd_ok, bwd_ok, moved;
  cell_t           self_c, down_c, diag_f, diag_b, lat_f;
  move_t           mv;
  row_t            lat_row;
  // out-of-range neighbours read as WALL; clamped indices keep the selects in range
  always_comb begin
    i = int'(idx_q);
    fwd_ok = dir_q ? idx_q != '0 : idx_q != LAST;
    bwd_ok = dir_q ? idx_q != LAST : idx_q != '0;
    fi = fwd_ok ? (dir_q ? i - 1 : i + 1) : i;
    bi = bwd_ok ? (dir_q ? i + 1 : i - 1) : i;
    self_c = cell_get(row_t'(reg_q), WIDTH, i);
    down_c = cell_get(row_t'(flr_q), WIDTH, i);
    diag_f = fwd_ok ? cell_get(row_t'(flr_q), WIDTH, fi) : WALL;
    diag_b = bwd_ok ? cell_get(row_t'(flr_q), WIDTH, bi) : WALL;
    lat_f = fwd_ok ? cell_get(row_t'(reg_q), WIDTH, fi) : WALL;
  end
`ifdef SAND_WATER_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  assign moved = mask_q[idx_q];
  assign mask_d = mask_q | ({{(WIDTH-1){1'b0}}, mv == MV_LAT} << fi);
  always_ff @(posedge clk)
    mask_q <= (reset || state_q == IDLE) ? '0 : state_q == SCAN ? mask_d : mask_q;
`else
  assign moved = 1'b0;
`endif
  sand_cell_rule u_rule (
    .self_i  (self_c),
    .down_i  (down_c),
    .diag_f_i(diag_f),
    .diag_b_i(diag_b),
    .lat_f_i (lat_f),
    .moved_i (moved),
    .move_o  (mv)
  );
  always_comb begin
    tgt = mv == MV_DOWN ? i : mv == MV_DIAG_B ? bi : fi;
    lat_row = mv == MV_LAT ? cell_set(row_t'(reg_q), WIDTH, fi, self_c) : row_t'(reg_q);
    flr_d = (mv == MV_NONE || mv == MV_LAT) ? flr_q : RW'(cell_set(row_t'(flr_q), WIDTH, tgt, self_c));
    reg_d = mv == MV_NONE ? reg_q : RW'(cell_set(lat_row, WIDTH, i, EMPTY));
    cnt_d = cnt_q + CW'(mv != MV_NONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      idx_q <= '0;
      reg_q <= '0;
      flr_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          reg_q <= in_region;
          flr_q <= in_floor;
          cnt_q <= '0;
          idx_q <= dir_q ? LAST : '0;
          state_q <= SCAN;
        end
        SCAN: begin
          reg_q <= reg_d;
          flr_q <= flr_d;
          cnt_q <= cnt_d;
          idx_q <= dir_q ? idx_q - IW'(1) : idx_q + IW'(1);
          if (idx_q == (dir_q ? '0 : LAST)) state_q <= DONE;
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          dir_q <= ALT_DIR & ~dir_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_region = reg_q;
  assign out_floor = flr_q;
  assign out_moved = cnt_q;
  assign out_dir = dir_q;
endmodule

// File: tb/tb_sand_row_engine.sv
// tb_sand_row_engine: directed and randomized checks of sand_row_engine against a cell-array reference model.
module tb_sand_row_engine;
  localparam int W = 8;
`ifdef SAND_WATER_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_region = '0, in_floor = '0;
  logic in_ready, out_valid, out_dir;
  logic [15:0] out_region, out_floor;
  logic [3:0] out_moved;
  int errors = 0, checks = 0, lat;
  bit exp_dir = 1'b0;
  logic [15:0] er, ef, rr, ff;
  int em;
  always #5 clk = ~clk;
  sand_row_engine #(.WIDTH(W), .ALT_DIR(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_region(in_region), .in_floor(in_floor), .out_valid(out_valid), .out_ready(out_ready),
    .out_region(out_region), .out_floor(out_floor), .out_moved(out_moved), .out_dir(out_dir)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // reference: cells as an int array, scanned in job order with the fall/slide rules
  function automatic void model(input logic [15:0] r_in, input logic [15:0] f_in, input bit d,
                                output logic [15:0] r_out, output logic [15:0] f_out, output int n);
    int r[W], f[W];
    bit mk[W];
    int k, fw, bw, t;
    n = 0;
    for (int j = 0; j < W; j++) begin
      r[j] = int'(r_in[(W-1-j)*2 +: 2]);
      f[j] = int'(f_in[(W-1-j)*2 +: 2]);
      mk[j] = 1'b0;
    end
    for (int s = 0; s < W; s++) begin
      k = d ? W - 1 - s : s;
      fw = d ? k - 1 : k + 1;
      bw = d ? k + 1 : k - 1;
      t = -1;
      if (mk[k] || !(r[k] == 1 || (WEN && r[k] == 3))) continue;
      if (f[k] == 0) t = k;
      else if (fw >= 0 && fw < W && f[fw] == 0) t = fw;
      else if (bw >= 0 && bw < W && f[bw] == 0) t = bw;
      if (t >= 0) begin
        f[t] = r[k];
        r[k] = 0;
        n++;
      end else if (WEN && r[k] == 3 && fw >= 0 && fw < W && r[fw] == 0) begin
        r[fw] = 3;
        mk[fw] = 1'b1;
        r[k] = 0;
        n++;
      end
    end
    for (int j = 0; j < W; j++) begin
      r_out[(W-1-j)*2 +: 2] = 2'(r[j]);
      f_out[(W-1-j)*2 +: 2] = 2'(f[j]);
    end
  endfunction
  task automatic run_job(input string tag, input logic [15:0] r, input logic [15:0] f,
                         input logic [15:0] xr, input logic [15:0] xf, input int xm);
    int n;
    @(negedge clk);
    in_region = r;
    in_floor = f;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_region"}, out_region, xr);
    chk({tag, "_floor"}, out_floor, xf);
    chk({tag, "_moved"}, out_moved, xm);
    chk({tag, "_dir"}, out_dir, exp_dir);
  endtask
  task automatic release_job(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_in_ready"}, in_ready, 1);
    chk({tag, "_rel_out_valid"}, out_valid, 0);
    exp_dir = ~exp_dir;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_region", out_region, 0);
    chk("rst_floor", out_floor, 0);
    chk("rst_moved", out_moved, 0);
    chk("rst_dir", out_dir, 0);
    reset = 1'b0;
    run_job("fall", 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1);
    release_job("fall");
    run_job("edge_r2l", 16'h0001, 16'h0002, 16'h0000, 16'h0006, 1);
    release_job("edge_r2l");
    run_job("conflict", 16'h5000, 16'h8800, 16'h1000, 16'h9800, 1);
    release_job("conflict");
    model(16'h1450, 16'h2008, exp_dir, er, ef, em);
    run_job("bp", 16'h1450, 16'h2008, er, ef, em);
    in_region = 16'hFFFF;
    in_floor = 16'h0000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_region", out_region, er);
      chk("bp_floor", out_floor, ef);
    end
    in_valid = 1'b0;
    release_job("bp");
    run_job("water", 16'h0300, 16'hAAAA, WEN ? 16'h00C0 : 16'h0300, 16'hAAAA, WEN ? 1 : 0);
    release_job("water");
    @(negedge clk);
    in_region = 16'h5555;
    in_floor = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_dir = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_region", out_region, 0);
    chk("abort_floor", out_floor, 0);
    chk("abort_moved", out_moved, 0);
    chk("abort_dir", out_dir, 0);
    for (int j = 0; j < 24; j++) begin
      rr = 16'($urandom);
      ff = 16'($urandom & $urandom);
      model(rr, ff, exp_dir, er, ef, em);
      run_job($sformatf("rand%0d", j), rr, ff, er, ef, em);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_job($sformatf("rand%0d", j));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
